// File: rtl/pattern_serializer.sv
// rtl/pattern_serializer.sv - parallel-to-serial frame transmitter with idle gap; optional even parity via PATTERN_SERIALIZER_PARITY_EN
module pattern_serializer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready,
    output logic             a_out,
    output logic             a_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    bit_cnt, bit_cnt_n;
    logic [GW-1:0]    gap_cnt, gap_cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n, shifted;
    logic             ready_n, a_out_n, a_valid_n, busy_n, done_n;
`ifdef PATTERN_SERIALIZER_PARITY_EN
    logic             par, par_n;
`endif

    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // Outputs are computed one cycle ahead and registered with the state.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        shreg_n   = shreg;
        ready_n   = 1'b0;
        a_out_n   = 1'b0;
        a_valid_n = 1'b0;
        busy_n    = 1'b1;
        done_n    = 1'b0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
        par_n     = par;
`endif
        shifted   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        case (state)
            IDLE: begin
                busy_n  = 1'b0;
                ready_n = 1'b1;
                if (valid_in && ready) begin
                    state_n   = SHIFT;
                    shreg_n   = data_in;
                    bit_cnt_n = '0;
                    a_out_n   = head(data_in);
                    a_valid_n = 1'b1;
                    busy_n    = 1'b1;
                    ready_n   = 1'b0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
                    par_n     = ^data_in;
`endif
                end
            end
            SHIFT: begin
                if (bit_cnt == CW'(WIDTH - 1)) begin
                    bit_cnt_n = '0;
                    gap_cnt_n = '0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
                    state_n   = PARITY;
                    a_out_n   = par;
                    a_valid_n = 1'b1;
`else
                    state_n   = GAP;
`endif
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    shreg_n   = shifted;
                    a_out_n   = head(shifted);
                    a_valid_n = 1'b1;
                end
            end
`ifdef PATTERN_SERIALIZER_PARITY_EN
            PARITY: begin
                state_n   = GAP;
                gap_cnt_n = '0;
            end
`endif
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_n   = IDLE;
                    gap_cnt_n = '0;
                    done_n    = 1'b1;
                    ready_n   = 1'b1;
                    busy_n    = 1'b0;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                ready_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            ready   <= 1'b1;
            a_out   <= 1'b0;
            a_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            gap_cnt <= gap_cnt_n;
            shreg   <= shreg_n;
            ready   <= ready_n;
            a_out   <= a_out_n;
            a_valid <= a_valid_n;
            busy    <= busy_n;
            done    <= done_n;
`ifdef PATTERN_SERIALIZER_PARITY_EN
            par     <= par_n;
`endif
        end
    end

endmodule
